// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array: fp32 words, operand pairs and the
// operand feeder state encoding.
package systolic_array_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t x;
        word_t w;
    } operand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular operand-pair buffer with a registered occupancy count and a
// first-word fall-through head (zero when empty).
module operand_fifo
    import systolic_array_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     push,
    input  operand_t push_data,
    input  logic     pop,
    output operand_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    operand_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// Edge-of-array driver for one PE: buffers operand pairs, issues a programmed
// number of MACs (back-to-back when possible) and captures the final sum.
module pe_operand_feeder
    import systolic_array_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  word_t              load_x,
    input  word_t              load_w,
    input  logic               start,
    input  logic [LEN_W-1:0]   length,
    output logic               busy,
    output logic               done,
    output word_t              result,
    output logic               proto_err,
    output word_t              pe_x,
    output word_t              pe_w,
    output logic               pe_input_start,
    input  logic               pe_stall,
    input  logic               pe_data_ready,
    input  word_t              pe_partial_sum,
    output feeder_state_t      dbg_state
);

    // Load handshake: a pair transfers on any cycle where load_valid and
    // load_ready are both high; load_ready depends only on registered state.

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] acked;
    logic [LEN_W-1:0] acked_next;
    logic             outstanding;
    logic             issue;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ack_seen;
    operand_t         fifo_head;
    operand_t         load_pair;

    assign load_pair = '{x: load_x, w: load_w};

    operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (load_valid),
        .push_data (load_pair),
        .pop       (issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A completion in the same cycle frees the PE, allowing gap-free reissue.
    assign issue = (state == ISSUE) && !fifo_empty && (issued < len_q)
                   && (!outstanding || pe_data_ready);

    assign ack_seen       = pe_data_ready && ((state == ISSUE) || (state == DRAIN));
    assign acked_next     = acked + 1'b1;
    assign pe_input_start = issue;
    assign pe_x           = fifo_head.x;
    assign pe_w           = fifo_head.w;
    assign load_ready     = !fifo_full;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign dbg_state      = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (length == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                // Last MAC may already complete here; skip DRAIN in that case.
                if (issued == len_q)
                    state_next = (pe_data_ready || !outstanding) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (pe_data_ready) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            acked       <= '0;
            outstanding <= 1'b0;
            result      <= '0;
            proto_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q       <= length;
                        issued      <= '0;
                        acked       <= '0;
                        outstanding <= 1'b0;
                        if (length == '0) result <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        issued      <= issued + 1'b1;
                        outstanding <= 1'b1;
                    end else if (pe_data_ready) begin
                        outstanding <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pe_data_ready) outstanding <= 1'b0;
                end
                default: ;
            endcase
            if (ack_seen) begin
                acked <= acked_next;
                if (acked_next == len_q) result <= pe_partial_sum;
            end
            if ((pe_data_ready && !outstanding) ||
                (!pe_stall && outstanding && !pe_data_ready))
                proto_err <= 1'b1;
        end
    end

endmodule
